ex_redirect_unit: RTL and testbench
===================================

Name: ex_redirect_unit

Overview:
- EX-stage branch/jump resolution block. It is the producer side of the PC redirect interface: it drives ex_redirect_taken and ex_branch_target into the PC register.
- The fetch path predicts not-taken (pc+4). This block detects taken branches and jumps, computes the target, and issues a one-shot redirect plus IF/ID and ID/EX flushes.
- It tracks the wrong-path shadow so that in-flight younger instructions cannot redirect or commit.

Parameters:
- XLEN, 32, datapath and address width.
- SHADOW_CYCLES, 2, number of advancing (non-stalled) EX cycles after a redirect during which EX-stage instructions are wrong-path; legal range 1..7.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_stall  in  1  EX stage held this cycle; the same instruction is presented again next cycle.
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_imm  in  XLEN  sign-extended immediate (B/J/I type).
- ex_rs1  in  XLEN  forwarded rs1 value.
- ex_rs2  in  XLEN  forwarded rs2 value.
- ex_funct3  in  3  branch condition (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111).
- ex_is_branch  in  1  conditional branch.
- ex_is_jal  in  1  JAL.
- ex_is_jalr  in  1  JALR.
- ex_redirect_taken  out  1  to the PC register: load ex_branch_target this cycle.
- ex_branch_target  out  XLEN  redirect target.
- flush_if_id  out  1  squash the IF/ID register.
- flush_id_ex  out  1  squash the ID/EX register.
- ex_kill  out  1  current EX instruction is wrong-path; suppress its writeback and memory access.
- ex_link_addr  out  XLEN  ex_pc+4, the JAL/JALR rd value.

Behaviour:
- Reset: state IDLE, shadow counter 0, fired flag 0. All outputs stay combinationally 0 while rst is high, including ex_link_addr. rst overrides every other input.
- Condition evaluation:
  - Signed compare for BLT/BGE; unsigned for BLTU/BGEU.
  - funct3 010/011 never taken.
  - JAL and JALR are always taken.
  - More than one of ex_is_branch/ex_is_jal/ex_is_jalr set: treat as not taken.
- Target computation, mod 2^XLEN with wrap allowed:
  - Branch and JAL: ex_pc + ex_imm.
  - JALR: (ex_rs1 + ex_imm) with bit 0 cleared.
- take = ex_valid & resolved-taken & state==IDLE & !fired.
- When take is high:
  - ex_redirect_taken, flush_if_id and flush_id_ex are asserted combinationally in the same cycle (0-cycle latency). The PC loads the target on the next edge.
  - ex_branch_target is valid only while ex_redirect_taken=1; otherwise it is driven to 0.
- One-shot rule for stalled redirects:
  - If take is asserted while ex_stall=1, set fired. While fired=1, redirect and flushes stay low.
  - Clear fired on the first cycle with ex_stall=0.
  - A redirect therefore pulses exactly once per instruction, regardless of stall length.
- FSM:
  - IDLE -> SHADOW on a cycle with take=1, loading counter=SHADOW_CYCLES. The transition happens whether or not ex_stall is set.
  - In SHADOW, the counter decrements on every cycle with ex_stall=0. SHADOW -> IDLE when the counter reaches 0.
  - In SHADOW, ex_kill = ex_valid. No redirect or flush can be issued from SHADOW.
  - In IDLE, ex_kill = 0.
- ex_link_addr = ex_pc + 4, computed combinationally and wrap-allowed. It is driven to 0 when ex_valid=0 or during reset.
- ex_stall and take in the same cycle: redirect is issued and the FSM enters SHADOW. Counter decrement starts on the first non-stalled cycle.
- Reset mid-shadow: FSM returns to IDLE and fired clears on the reset edge.

Optional Feature:
- Macro: EX_REDIRECT_MISALIGN_EN.
- Defined:
  - Added output misalign_exc (1 bit). It is asserted instead of a redirect when take would fire and target[1] is 1 (IALIGN=32).
  - When misalign_exc fires, ex_redirect_taken stays 0, no flush is issued, and the FSM stays IDLE.
- Not defined: port absent; the target is used unchecked.

Decomposition:
- Shared package constants: the BR_* funct3 encodings, XLEN, and the FSM state encoding (IDLE, SHADOW).
- Natural sub-module: ex_branch_cmp, the combinational comparator taking funct3/rs1/rs2 and producing cond_true. The FSM, one-shot logic and target adder stay in the top module.

Test Plan:
- BEQ, ex_pc=0x100, imm=0x20, rs1=rs2=5 -> ex_redirect_taken=1 and target=0x120 in the same cycle; flushes=1; then ex_kill=1 for the next 2 non-stalled valid cycles; next redirect is possible on the 3rd.
- BLT, rs1=0xFFFFFFFF, rs2=1 -> taken (signed). BLTU with the same operands -> not taken; redirect stays 0 and FSM stays IDLE.
- JALR, rs1=0x203, imm=0x4 -> target=0x206; ex_link_addr=ex_pc+4.
- JAL held with ex_stall=1 for 3 cycles -> exactly one redirect pulse in the first cycle; shadow counter holds at 2 until ex_stall=0.
- Taken branch in EX while in SHADOW (second branch at the next valid slot) -> no redirect, ex_kill=1.
- rst=1 while in SHADOW with counter=1 -> next cycle IDLE; a taken BNE immediately after reset redirects normally.
- With EX_REDIRECT_MISALIGN_EN defined: JAL ex_pc=0x0, imm=0x6 -> misalign_exc=1 and ex_redirect_taken=0.

Source files
------------

// File: rtl/ex_redirect_unit_pkg.sv
// Shared constants for the EX-stage redirect unit: branch funct3 codes,
// datapath width and the shadow FSM state encoding.
package ex_redirect_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam int unsigned ST_W = 1;
  localparam logic [ST_W-1:0] ST_IDLE   = 1'b0;
  localparam logic [ST_W-1:0] ST_SHADOW = 1'b1;

  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/ex_branch_cmp.sv
// Branch condition comparator: evaluates funct3 against rs1/rs2.
module ex_branch_cmp
  import ex_redirect_unit_pkg::*;
#(
  parameter int unsigned W = XLEN
) (
  input  logic [2:0]   funct3,
  input  logic [W-1:0] rs1,
  input  logic [W-1:0] rs2,
  output logic         cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (funct3)
      BR_EQ:   cond_true = (rs1 == rs2);
      BR_NE:   cond_true = (rs1 != rs2);
      BR_LT:   cond_true = ($signed(rs1) < $signed(rs2));
      BR_GE:   cond_true = ($signed(rs1) >= $signed(rs2));
      BR_LTU:  cond_true = (rs1 < rs2);
      BR_GEU:  cond_true = (rs1 >= rs2);
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_redirect_unit.sv
// EX-stage branch/jump resolution: one-shot PC redirect, pipeline flushes and
// wrong-path shadow tracking. Optional macro: EX_REDIRECT_MISALIGN_EN.
module ex_redirect_unit
  import ex_redirect_unit_pkg::*;
#(
  parameter int unsigned XLEN_P        = XLEN,
  parameter int unsigned SHADOW_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_stall,
  input  logic [XLEN_P-1:0] ex_pc,
  input  logic [XLEN_P-1:0] ex_imm,
  input  logic [XLEN_P-1:0] ex_rs1,
  input  logic [XLEN_P-1:0] ex_rs2,
  input  logic [2:0]        ex_funct3,
  input  logic              ex_is_branch,
  input  logic              ex_is_jal,
  input  logic              ex_is_jalr,
  output logic              ex_redirect_taken,
  output logic [XLEN_P-1:0] ex_branch_target,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              ex_kill,
`ifdef EX_REDIRECT_MISALIGN_EN
  output logic              misalign_exc,
`endif
  output logic [XLEN_P-1:0] ex_link_addr
);

  localparam logic [CNT_W-1:0] SHADOW_LOAD = CNT_W'(SHADOW_CYCLES);

  logic [ST_W-1:0]   state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fired_q, fired_d;

  logic              cond_true;
  logic              resolved_taken;
  logic              take;
  logic              fire;
  logic [XLEN_P-1:0] target;

  ex_branch_cmp #(.W(XLEN_P)) u_cmp (
    .funct3    (ex_funct3),
    .rs1       (ex_rs1),
    .rs2       (ex_rs2),
    .cond_true (cond_true)
  );

  // Exactly one control-flow type must be flagged; ambiguous encodings fall through.
  assign resolved_taken =
      (ex_is_branch & ~ex_is_jal & ~ex_is_jalr & cond_true) |
      (ex_is_jal & ~ex_is_branch & ~ex_is_jalr) |
      (ex_is_jalr & ~ex_is_branch & ~ex_is_jal);

  always_comb begin
    if (ex_is_jalr) target = (ex_rs1 + ex_imm) & ~XLEN_P'(1);
    else            target = ex_pc + ex_imm;
  end

  assign take = ~rst & ex_valid & resolved_taken & (state_q == ST_IDLE) & ~fired_q;

`ifdef EX_REDIRECT_MISALIGN_EN
  assign fire         = take & ~target[1];
  assign misalign_exc = take & target[1];
`else
  assign fire = take;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fired_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fired_q <= fired_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    fired_d           = fired_q;
    ex_redirect_taken = 1'b0;
    ex_branch_target  = '0;
    flush_if_id       = 1'b0;
    flush_id_ex       = 1'b0;
    ex_kill           = 1'b0;
    ex_link_addr      = '0;

    if (!rst && ex_valid) ex_link_addr = ex_pc + XLEN_P'(4);

    if (fire) begin
      ex_redirect_taken = 1'b1;
      ex_branch_target  = target;
      flush_if_id       = 1'b1;
      flush_id_ex       = 1'b1;
    end

    // Held redirect must not re-fire while the same instruction sits in EX.
    if (fire && ex_stall) fired_d = 1'b1;
    else if (!ex_stall)   fired_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          state_d = ST_SHADOW;
          cnt_d   = SHADOW_LOAD;
        end
      end
      ST_SHADOW: begin
        ex_kill = ~rst & ex_valid;
        if (!ex_stall) begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ex_redirect_unit.sv
// Directed self-checking bench for ex_redirect_unit; covers the optional
// EX_REDIRECT_MISALIGN_EN port when that macro is defined.
module tb_ex_redirect_unit;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_stall;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1;
  logic [31:0] ex_rs2;
  logic [2:0]  ex_funct3;
  logic        ex_is_branch;
  logic        ex_is_jal;
  logic        ex_is_jalr;
  logic        ex_redirect_taken;
  logic [31:0] ex_branch_target;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        ex_kill;
  logic [31:0] ex_link_addr;
`ifdef EX_REDIRECT_MISALIGN_EN
  logic        misalign_exc;
`endif

  int checks = 0;
  int errors = 0;

  ex_redirect_unit dut (
    .clk               (clk),
    .rst               (rst),
    .ex_valid          (ex_valid),
    .ex_stall          (ex_stall),
    .ex_pc             (ex_pc),
    .ex_imm            (ex_imm),
    .ex_rs1            (ex_rs1),
    .ex_rs2            (ex_rs2),
    .ex_funct3         (ex_funct3),
    .ex_is_branch      (ex_is_branch),
    .ex_is_jal         (ex_is_jal),
    .ex_is_jalr        (ex_is_jalr),
    .ex_redirect_taken (ex_redirect_taken),
    .ex_branch_target  (ex_branch_target),
    .flush_if_id       (flush_if_id),
    .flush_id_ex       (flush_id_ex),
    .ex_kill           (ex_kill),
`ifdef EX_REDIRECT_MISALIGN_EN
    .misalign_exc      (misalign_exc),
`endif
    .ex_link_addr      (ex_link_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // kind: 0 none, 1 branch, 2 jal, 3 jalr, 4 branch+jal
  task automatic drive(input logic v, input logic st, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] f3, input int kind);
    ex_valid     = v;
    ex_stall     = st;
    ex_pc        = pc;
    ex_imm       = imm;
    ex_rs1       = a;
    ex_rs2       = b;
    ex_funct3    = f3;
    ex_is_branch = (kind == 1) || (kind == 4);
    ex_is_jal    = (kind == 2) || (kind == 4);
    ex_is_jalr   = (kind == 3);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000, 0);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h100, 32'h20, 32'h5, 32'h5, 3'b000, 2);
    check("rst_redirect", 32'(ex_redirect_taken), 32'h0);
    check("rst_target", ex_branch_target, 32'h0);
    check("rst_link", ex_link_addr, 32'h0);
    check("rst_flush", 32'({flush_if_id, flush_id_ex}), 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Taken BEQ: same-cycle redirect and flushes
    drive(1'b1, 1'b0, 32'h100, 32'h20, 32'h5, 32'h5, 3'b000, 1);
    check("beq_redirect", 32'(ex_redirect_taken), 32'h1);
    check("beq_target", ex_branch_target, 32'h120);
    check("beq_flush", 32'({flush_if_id, flush_id_ex}), 32'h3);
    check("beq_kill", 32'(ex_kill), 32'h0);
    check("beq_link", ex_link_addr, 32'h104);
    tick();
    drive(1'b1, 1'b0, 32'h120, 32'h0, 32'h0, 32'h0, 3'b000, 0);
    check("shadow1_kill", 32'(ex_kill), 32'h1);
    tick();
    // Taken branch in shadow: no redirect, killed
    drive(1'b1, 1'b0, 32'h124, 32'h40, 32'h1, 32'h1, 3'b000, 1);
    check("shadow2_kill", 32'(ex_kill), 32'h1);
    check("shadow2_redirect", 32'(ex_redirect_taken), 32'h0);
    check("shadow2_target", ex_branch_target, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h200, 32'h10, 32'h7, 32'h7, 3'b000, 1);
    check("third_redirect", 32'(ex_redirect_taken), 32'h1);
    check("third_target", ex_branch_target, 32'h210);
    check("third_kill", 32'(ex_kill), 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h210, 32'h0, 32'h0, 32'h0, 3'b000, 0);
    check("invalid_kill", 32'(ex_kill), 32'h0);
    check("invalid_link", ex_link_addr, 32'h0);
    drain();

    // Signed vs unsigned less-than
    drive(1'b1, 1'b0, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'h1, 3'b100, 1);
    check("blt_redirect", 32'(ex_redirect_taken), 32'h1);
    check("blt_target", ex_branch_target, 32'h340);
    tick();
    drain();
    drive(1'b1, 1'b0, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'h1, 3'b110, 1);
    check("bltu_redirect", 32'(ex_redirect_taken), 32'h0);
    check("bltu_target", ex_branch_target, 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h304, 32'h0, 32'h0, 32'h0, 3'b000, 0);
    check("bltu_idle_kill", 32'(ex_kill), 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h308, 32'h8, 32'h3, 32'h9, 3'b111, 1);
    check("bgeu_nt_redirect", 32'(ex_redirect_taken), 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h30C, 32'h8, 32'h3, 32'h3, 3'b010, 1);
    check("f3_010_redirect", 32'(ex_redirect_taken), 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h310, 32'h8, 32'h3, 32'h3, 3'b000, 4);
    check("multi_type_redirect", 32'(ex_redirect_taken), 32'h0);
    tick();

    // JALR clears bit 0
    drive(1'b1, 1'b0, 32'h400, 32'h4, 32'h203, 32'h0, 3'b000, 3);
    check("jalr_redirect", 32'(ex_redirect_taken), 32'h1);
    check("jalr_target", ex_branch_target, 32'h206);
    check("jalr_link", ex_link_addr, 32'h404);
    tick();
    drain();

    // Stalled JAL: single pulse, counter held during the stall
    drive(1'b1, 1'b1, 32'h500, 32'h100, 32'h0, 32'h0, 3'b000, 2);
    check("stall_c1_redirect", 32'(ex_redirect_taken), 32'h1);
    check("stall_c1_target", ex_branch_target, 32'h600);
    tick();
    drive(1'b1, 1'b1, 32'h500, 32'h100, 32'h0, 32'h0, 3'b000, 2);
    check("stall_c2_redirect", 32'(ex_redirect_taken), 32'h0);
    check("stall_c2_flush", 32'(flush_if_id), 32'h0);
    tick();
    drive(1'b1, 1'b1, 32'h500, 32'h100, 32'h0, 32'h0, 3'b000, 2);
    check("stall_c3_redirect", 32'(ex_redirect_taken), 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h500, 32'h100, 32'h0, 32'h0, 3'b000, 2);
    check("stall_release_redirect", 32'(ex_redirect_taken), 32'h0);
    check("stall_release_kill", 32'(ex_kill), 32'h1);
    tick();
    drive(1'b1, 1'b0, 32'h600, 32'h0, 32'h0, 32'h0, 3'b000, 0);
    check("stall_post1_kill", 32'(ex_kill), 32'h1);
    tick();
    drive(1'b1, 1'b0, 32'h604, 32'h0, 32'h0, 32'h0, 3'b000, 0);
    check("stall_post2_kill", 32'(ex_kill), 32'h0);
    tick();

    // Reset mid-shadow, then a taken BNE redirects normally
    drive(1'b1, 1'b0, 32'h700, 32'h10, 32'h1, 32'h1, 3'b000, 1);
    check("pre_rst_redirect", 32'(ex_redirect_taken), 32'h1);
    tick();
    drive(1'b1, 1'b0, 32'h710, 32'h0, 32'h0, 32'h0, 3'b000, 0);
    check("pre_rst_kill", 32'(ex_kill), 32'h1);
    tick();
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h714, 32'h0, 32'h0, 32'h0, 3'b000, 0);
    check("mid_rst_kill", 32'(ex_kill), 32'h0);
    check("mid_rst_link", ex_link_addr, 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b1, 1'b0, 32'h800, 32'hFFFF_FFF0, 32'h1, 32'h2, 3'b001, 1);
    check("post_rst_redirect", 32'(ex_redirect_taken), 32'h1);
    check("post_rst_target", ex_branch_target, 32'h7F0);
    check("post_rst_kill", 32'(ex_kill), 32'h0);
    tick();
    drain();

    // Address wrap on target and link
    drive(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h8, 32'h0, 32'h0, 3'b000, 2);
    check("wrap_target", ex_branch_target, 32'h4);
    check("wrap_link", ex_link_addr, 32'h0);
    tick();
    drain();

`ifdef EX_REDIRECT_MISALIGN_EN
    drive(1'b1, 1'b0, 32'h0, 32'h6, 32'h0, 32'h0, 3'b000, 2);
    check("mis_exc", 32'(misalign_exc), 32'h1);
    check("mis_redirect", 32'(ex_redirect_taken), 32'h0);
    check("mis_flush", 32'(flush_id_ex), 32'h0);
    tick();
    drive(1'b1, 1'b0, 32'h4, 32'h0, 32'h0, 32'h0, 3'b000, 0);
    check("mis_idle_kill", 32'(ex_kill), 32'h0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
